// File: rtl/fpnew_i2fcast_multi_if.sv
`timescale 1ns/1ps
// Request/response bundle for the multi-format integer-to-float cast unit.
interface fpnew_i2fcast_multi_if #(
    parameter int unsigned IW       = 64,
    parameter int unsigned FW       = 64,
    parameter int unsigned TagWidth = 1
);
    logic [IW-1:0]       operand_i;
    logic [2:0]          rnd_mode_i;
    logic                op_mod_i;
    logic [1:0]          int_fmt_i;
    logic [2:0]          dst_fmt_i;
    logic [TagWidth-1:0] tag_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                flush_i;
    logic [FW-1:0]       result_o;
    logic [4:0]          status_o;
    logic [TagWidth-1:0] tag_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                busy_o;

    // Producer/consumer side.
    modport master (
        output operand_i, rnd_mode_i, op_mod_i, int_fmt_i, dst_fmt_i, tag_i,
        output in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
    );

    // Conversion unit side.
    modport slave (
        input  operand_i, rnd_mode_i, op_mod_i, int_fmt_i, dst_fmt_i, tag_i,
        input  in_valid_i, flush_i, out_ready_i,
        output in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/fpnew_i2fcast_multi.sv
`timescale 1ns/1ps
// Integer-to-float conversion for INT8..INT64 into FP32/FP64/FP16/FP8/FP16ALT,
// IEEE rounding, NaN-boxed results, elastic valid/ready output pipeline.
module fpnew_i2fcast_multi #(
    parameter logic [4:0]  FpFmtConfig  = 5'b11111,
    parameter logic [3:0]  IntFmtConfig = 4'b1111,
    parameter int unsigned NumPipeRegs  = 1,
    parameter int unsigned TagWidth     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fpnew_i2fcast_multi_if.slave  bus
);
    localparam int unsigned IW   = IntFmtConfig[3] ? 64 : IntFmtConfig[2] ? 32 :
                                   IntFmtConfig[1] ? 16 : 8;
    localparam int unsigned FW   = FpFmtConfig[1] ? 64 : FpFmtConfig[0] ? 32 :
                                   (FpFmtConfig[2] | FpFmtConfig[4]) ? 16 : 8;
    localparam int unsigned IDXW = $clog2(IW);
    localparam int unsigned LZW  = IDXW + 1;
    localparam int unsigned NW   = IW + 64;
    localparam int unsigned VW   = 66;
    localparam int unsigned PW   = FW + 5 + TagWidth;

    logic              int_ok, fp_ok;
    int unsigned       exp_bits, man_bits;
    int unsigned       src_w, src_top, exp_unb, bias;
    logic [IW-1:0]     ext, mag;
    logic              sign;
    logic [LZW-1:0]    lzc;
    logic [NW-1:0]     norm, frac, rest;
    logic [63:0]       mant;
    logic              guard, sticky, rup, ovf, to_inf;
    logic [VW-1:0]     val, max_e, inf_v, body, pk, box;
    logic [FW-1:0]     res_c;
    logic [4:0]        status_c;
    logic [PW-1:0]     pay_c;

    // Decode destination format geometry and which formats are enabled.
    always_comb begin
        int_ok   = IntFmtConfig[bus.int_fmt_i];
        fp_ok    = 1'b0;
        exp_bits = 8;
        man_bits = 23;
        case (bus.dst_fmt_i)
            3'd0: begin fp_ok = FpFmtConfig[0]; exp_bits = 8;  man_bits = 23; end
            3'd1: begin fp_ok = FpFmtConfig[1]; exp_bits = 11; man_bits = 52; end
            3'd2: begin fp_ok = FpFmtConfig[2]; exp_bits = 5;  man_bits = 10; end
            3'd3: begin fp_ok = FpFmtConfig[3]; exp_bits = 5;  man_bits = 2;  end
            3'd4: begin fp_ok = FpFmtConfig[4]; exp_bits = 8;  man_bits = 7;  end
            default: ;
        endcase
    end

    // Extend the source to IW bits, take its magnitude and count leading zeros.
    always_comb begin
        src_w   = 32'd8 << bus.int_fmt_i;
        src_top = (src_w > IW) ? IW : src_w;
        ext     = '0;
        for (int unsigned i = 0; i < IW; i++) begin
            ext[i] = (i < src_top) ? bus.operand_i[i]
                                   : (~bus.op_mod_i & bus.operand_i[IDXW'(src_top - 1)]);
        end
        sign = ~bus.op_mod_i & ext[IW-1];
        // Negating the most negative value wraps to the unsigned 2^(IW-1), as wanted.
        mag  = sign ? (~ext + IW'(1)) : ext;
        lzc  = LZW'(IW);
        for (int unsigned i = 0; i < IW; i++) begin
            if (mag[i]) lzc = LZW'(IW - 1 - i);
        end
    end

    // Normalise, round, handle overflow/zero/invalid and NaN-box.
    always_comb begin
        exp_unb = IW - 1 - 32'(lzc);
        bias    = (32'd1 << (exp_bits - 1)) - 1;
        norm    = {mag, 64'd0} << lzc;
        frac    = norm << 1;
        mant    = 64'(frac >> (NW - man_bits));
        rest    = frac << man_bits;
        guard   = rest[NW-1];
        sticky  = |rest[NW-2:0];
        case (bus.rnd_mode_i)
            3'd0:    rup = guard & (sticky | mant[0]);
            3'd1:    rup = 1'b0;
            3'd2:    rup = (guard | sticky) & sign;
            3'd3:    rup = (guard | sticky) & ~sign;
            3'd4:    rup = guard;
            default: rup = guard & (sticky | mant[0]);
        endcase
        // A carry out of the mantissa ripples straight into the exponent field.
        val   = (VW'(exp_unb + bias) << man_bits) + VW'(mant) + VW'(rup);
        max_e = (VW'(1) << exp_bits) - VW'(1);
        inf_v = max_e << man_bits;
        ovf   = (val >> man_bits) >= max_e;
        case (bus.rnd_mode_i)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = sign;
            3'd3:    to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        body     = ovf ? (to_inf ? inf_v : inf_v - VW'(1)) : val;
        pk       = body | (VW'(sign) << (exp_bits + man_bits));
        status_c = {2'b00, ovf, 1'b0, guard | sticky | ovf};
        if (mag == '0) begin
            pk       = '0;
            status_c = '0;
        end
        if (!(int_ok && fp_ok)) begin
            pk       = inf_v | (VW'(1) << (man_bits - 1));
            status_c = 5'b10000;
        end
        box   = ~((VW'(1) << (exp_bits + man_bits + 1)) - VW'(1));
        res_c = FW'(pk | box);
    end

    assign pay_c = {res_c, status_c, bus.tag_i};

    if (NumPipeRegs == 0) begin : gen_comb
        assign bus.out_valid_o = bus.in_valid_i;
        assign bus.in_ready_o  = bus.out_ready_i;
        assign bus.busy_o      = 1'b0;
        assign {bus.result_o, bus.status_o, bus.tag_o} = pay_c;
    end else begin : gen_pipe
        logic [NumPipeRegs-1:0] vld;
        logic [NumPipeRegs:0]   rdy;
        logic [PW-1:0]          dat [NumPipeRegs];

        // Ready chains back from the consumer; a stage accepts when empty or draining.
        always_comb begin
            rdy[NumPipeRegs] = bus.out_ready_i;
            for (int k = int'(NumPipeRegs) - 1; k >= 0; k--) begin
                rdy[k] = ~vld[k] | rdy[k+1];
            end
        end

        // Stage registers: flush drops everything, payload only moves on transfer.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld <= '0;
                for (int unsigned k = 0; k < NumPipeRegs; k++) dat[k] <= '0;
            end else if (bus.flush_i) begin
                vld <= '0;
            end else begin
                if (rdy[0]) begin
                    vld[0] <= bus.in_valid_i;
                    if (bus.in_valid_i) dat[0] <= pay_c;
                end
                for (int unsigned k = 1; k < NumPipeRegs; k++) begin
                    if (rdy[k]) begin
                        vld[k] <= vld[k-1];
                        if (vld[k-1]) dat[k] <= dat[k-1];
                    end
                end
            end
        end

        assign bus.in_ready_o  = rdy[0] | bus.flush_i;
        assign bus.out_valid_o = vld[NumPipeRegs-1];
        assign bus.busy_o      = |vld;
        assign {bus.result_o, bus.status_o, bus.tag_o} = dat[NumPipeRegs-1];
    end
endmodule

// File: tb/tb_fpnew_i2fcast_multi.sv
`timescale 1ns/1ps
// Bench for fpnew_i2fcast_multi: directed corner cases, pipeline/flush/reset
// behaviour, and randomized operations against an arithmetic reference model.
module tb_fpnew_i2fcast_multi;
    localparam int unsigned IW = 64;
    localparam int unsigned FW = 64;
    localparam int unsigned TW = 4;
    localparam int unsigned NP = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fpnew_i2fcast_multi_if #(.IW(IW), .FW(FW), .TagWidth(TW)) bus ();

    fpnew_i2fcast_multi #(
        .FpFmtConfig (5'b11111),
        .IntFmtConfig(4'b1111),
        .NumPipeRegs (NP),
        .TagWidth    (TW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: exact integer value, rounded by quotient/remainder against half an ulp.
    function automatic logic [68:0] model(input logic [63:0] op, input logic [2:0] rm,
                                          input logic um, input logic [1:0] ifmt,
                                          input logic [2:0] dfmt);
        int w, e, sh, ebits, mbits, bias, bexp;
        logic [127:0] raw, mag, q, r, half, one, bits, full, maxe;
        logic neg, inexact, up, to_inf;
        logic [4:0] st;
        w = 8 << ifmt;
        case (dfmt)
            3'd0:    begin ebits = 8;  mbits = 23; end
            3'd1:    begin ebits = 11; mbits = 52; end
            3'd2:    begin ebits = 5;  mbits = 10; end
            3'd3:    begin ebits = 5;  mbits = 2;  end
            default: begin ebits = 8;  mbits = 7;  end
        endcase
        one = 128'd1;
        raw = '0;
        for (int i = 0; i < w; i++) raw[i] = op[i];
        neg  = !um && raw[7'(w - 1)];
        mag  = neg ? ((one << w) - raw) : raw;
        bias = (1 << (ebits - 1)) - 1;
        maxe = (one << ebits) - one;
        up   = 1'b0;
        if (mag == '0) begin
            bits = '0;
            st   = '0;
            neg  = 1'b0;
        end else begin
            e = 0;
            for (int i = 0; i < 128; i++) if (mag[i]) e = i;
            sh = e - mbits;
            if (sh <= 0) begin
                q = mag << (-sh); r = '0; half = '0;
            end else begin
                q = mag >> sh; r = mag - (q << sh); half = one << (sh - 1);
            end
            inexact = (r != '0);
            case (rm)
                3'd0: up = inexact && ((r > half) || (r == half && q[0]));
                3'd2: up = inexact && neg;
                3'd3: up = inexact && !neg;
                3'd4: up = inexact && (r >= half);
                default: up = 1'b0;
            endcase
            q = q + 128'(up);
            if (q == (one << (mbits + 1))) begin
                q = q >> 1;
                e++;
            end
            bexp = e + bias;
            if (128'(bexp) >= maxe) begin
                to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd2 && neg) || (rm == 3'd3 && !neg);
                bits = maxe << mbits;
                if (!to_inf) bits = bits - one;
                st = 5'b00101;
            end else begin
                bits = (128'(bexp) << mbits) | (q - (one << mbits));
                st   = {4'b0000, inexact};
            end
        end
        full = bits | (128'(neg) << (ebits + mbits));
        for (int i = 0; i < 64; i++) if (i > ebits + mbits) full[i] = 1'b1;
        return {full[63:0], st};
    endfunction

    // One operation through an idle pipeline with the consumer always ready.
    task automatic run_op(input logic [63:0] op, input logic [2:0] rm, input logic um,
                          input logic [1:0] ifmt, input logic [2:0] dfmt, input logic [3:0] tg,
                          input string name, input logic [63:0] er, input logic [4:0] es);
        int n;
        bus.operand_i   = op;
        bus.rnd_mode_i  = rm;
        bus.op_mod_i    = um;
        bus.int_fmt_i   = ifmt;
        bus.dst_fmt_i   = dfmt;
        bus.tag_i       = tg;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready_o && n < 20) begin step(); n++; end
        if (!bus.in_ready_o) check({name, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
        step();
        bus.in_valid_i = 1'b0;
        n = 0;
        while (!bus.out_valid_o && n < 20) begin step(); n++; end
        if (!bus.out_valid_o) begin
            check({name, "_timeout"}, 64'(bus.out_valid_o), 64'd1);
        end else begin
            check({name, "_lat"},    64'(n), 64'(NP - 1));
            check({name, "_res"},    bus.result_o, er);
            check({name, "_status"}, 64'(bus.status_o), 64'(es));
            check({name, "_tag"},    64'(bus.tag_o), 64'(tg));
        end
        step();
    endtask

    task automatic run_rand(input int idx);
        logic [63:0] op;
        logic [68:0] ex;
        logic [2:0]  rm, df;
        logic [1:0]  ifm;
        logic        um;
        int          k;
        case ($urandom_range(0, 3))
            0: op = {$urandom, $urandom};
            1: op = 64'($urandom_range(0, 8)) | ({$urandom, $urandom} & 64'hFF00_0000_0000_0000);
            2: begin k = $urandom_range(1, 63); op = {$urandom, $urandom} >> k; end
            default: begin
                k  = $urandom_range(1, 40);
                op = (64'($urandom_range(1, 15)) << (k + 1)) | (64'd1 << (k - 1));
                if ($urandom_range(0, 1) == 1) op = ~op + 64'd1;
            end
        endcase
        rm  = 3'($urandom_range(0, 4));
        df  = 3'($urandom_range(0, 4));
        ifm = 2'($urandom_range(0, 3));
        um  = 1'($urandom_range(0, 1));
        ex  = model(op, rm, um, ifm, df);
        run_op(op, rm, um, ifm, df, 4'(idx), $sformatf("rand%0d", idx), ex[68:5], ex[4:0]);
    endtask

    logic [63:0] s_op  [4];
    logic [63:0] s_res [4];
    logic [68:0] mx;
    int sent, got, c, first_valid;

    initial begin
        bus.operand_i   = '0;
        bus.rnd_mode_i  = '0;
        bus.op_mod_i    = 1'b0;
        bus.int_fmt_i   = '0;
        bus.dst_fmt_i   = '0;
        bus.tag_i       = '0;
        bus.in_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_busy",      64'(bus.busy_o),      64'd0);
        check("rst_result",    bus.result_o,         64'd0);
        check("rst_status",    64'(bus.status_o),    64'd0);
        check("rst_tag",       64'(bus.tag_o),       64'd0);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        step();

        // Directed corner cases (int_fmt: 0=INT8..3=INT64; dst: 0=FP32,1=FP64,2=FP16,3=FP8,4=FP16ALT).
        run_op(64'hFFFF_FFFF, 3'd0, 1'b0, 2'd2, 3'd0, 4'h1, "m1_fp32",  64'hFFFF_FFFF_BF80_0000, 5'b00000);
        run_op(64'd16777217,  3'd0, 1'b0, 2'd2, 3'd0, 4'h2, "tie_rne",  64'hFFFF_FFFF_4B80_0000, 5'b00001);
        run_op(64'd16777217,  3'd3, 1'b0, 2'd2, 3'd0, 4'h3, "tie_rup",  64'hFFFF_FFFF_4B80_0001, 5'b00001);
        run_op(64'd70000,     3'd0, 1'b0, 2'd2, 3'd2, 4'h4, "of_rne",   64'hFFFF_FFFF_FFFF_7C00, 5'b00101);
        run_op(64'd70000,     3'd1, 1'b0, 2'd2, 3'd2, 4'h5, "of_rtz",   64'hFFFF_FFFF_FFFF_7BFF, 5'b00101);
        run_op(64'hFF,        3'd0, 1'b1, 2'd0, 3'd0, 4'h6, "u8_255",   64'hFFFF_FFFF_437F_0000, 5'b00000);
        run_op(64'hFF,        3'd0, 1'b0, 2'd0, 3'd0, 4'h7, "s8_m1",    64'hFFFF_FFFF_BF80_0000, 5'b00000);
        run_op(64'd0,         3'd2, 1'b0, 2'd3, 3'd1, 4'h8, "zero_rdn", 64'h0,                   5'b00000);
        run_op(64'h8000_0000_0000_0000, 3'd0, 1'b0, 2'd3, 3'd1, 4'h9, "min64", 64'hC3E0_0000_0000_0000, 5'b00000);
        run_op(64'd3,         3'd0, 1'b0, 2'd1, 3'd3, 4'hA, "fp8_3",    64'hFFFF_FFFF_FFFF_FF42, 5'b00000);
        run_op(64'h8000,      3'd0, 1'b0, 2'd1, 3'd4, 4'hB, "bf16_min", 64'hFFFF_FFFF_FFFF_C700, 5'b00000);
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 3'd2, 1'b0, 2'd3, 3'd2, 4'hC, "m7_rdn", 64'hFFFF_FFFF_FFFF_C700, 5'b00000);

        // Streaming with a 3-cycle consumer stall: latency, back-pressure, stability, order.
        for (int i = 0; i < 4; i++) begin
            s_op[i]  = 64'd100 * 64'(i + 1) + 64'd1;
            mx       = model(s_op[i], 3'd0, 1'b0, 2'd2, 3'd0);
            s_res[i] = mx[68:5];
        end
        sent = 0; got = 0; c = 0; first_valid = -1;
        while (got < 4 && c < 40) begin
            bus.in_valid_i  = (sent < 4);
            bus.operand_i   = s_op[sent % 4];
            bus.tag_i       = 4'(sent + 4);
            bus.rnd_mode_i  = 3'd0;
            bus.op_mod_i    = 1'b0;
            bus.int_fmt_i   = 2'd2;
            bus.dst_fmt_i   = 3'd0;
            bus.out_ready_i = (c >= 5);
            #1;
            if (c == 2) check("stream_in_ready_held", 64'(bus.in_ready_o), 64'd0);
            if (bus.out_valid_o) begin
                if (first_valid < 0) first_valid = c;
                check($sformatf("stream_res%0d_c%0d", got, c), bus.result_o, s_res[got]);
                check($sformatf("stream_tag%0d_c%0d", got, c), 64'(bus.tag_o), 64'(got + 4));
                if (bus.out_ready_i) got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) sent++;
            step();
            c++;
        end
        bus.in_valid_i = 1'b0;
        check("stream_count",   64'(got), 64'd4);
        check("stream_latency", 64'(first_valid), 64'(NP));

        // Flush with two operations in flight; the op presented during flush is dropped.
        bus.out_ready_i = 1'b0;
        bus.operand_i   = 64'd5;
        bus.in_valid_i  = 1'b1;
        step();
        step();
        check("flush_busy_before", 64'(bus.busy_o), 64'd1);
        bus.flush_i = 1'b1;
        #1;
        check("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("flush_busy",      64'(bus.busy_o),      64'd0);
        step();
        check("flush_no_capture", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset in the middle of a stalled stream.
        bus.in_valid_i = 1'b1;
        bus.operand_i  = 64'd9;
        bus.tag_i      = 4'hF;
        step();
        step();
        bus.in_valid_i = 1'b0;
        check("arst_busy_before", 64'(bus.busy_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("arst_busy",      64'(bus.busy_o),      64'd0);
        check("arst_result",    bus.result_o,         64'd0);
        check("arst_tag",       64'(bus.tag_o),       64'd0);
        #1 rst_i = 1'b0;
        step();

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) run_rand(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
